// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned MAX_W   = 32;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] div;
        logic [MAX_W-1:0] high;
    } eff_cfg_t;

    // Divisor floors at MIN_DIV; high-time saturates at the divisor (constant-high output).
    function automatic eff_cfg_t sanitise(input logic [MAX_W-1:0] div,
                                          input logic [MAX_W-1:0] high);
        eff_cfg_t r;
        r.div  = (div < MAX_W'(MIN_DIV)) ? MAX_W'(MIN_DIV) : div;
        r.high = (high > r.div) ? r.div : high;
        return r;
    endfunction

endpackage

// File: rtl/clk_div_gen_ch.sv
// One divider channel: STOP/RUN/DRAIN FSM, period counter, shadow config reloaded at period boundaries.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 31,
    parameter int unsigned DEF_DIV  = 125000000,
    parameter int unsigned DEF_HIGH = 62500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    input  logic             wr_inv,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam eff_cfg_t DEF_EFF = sanitise(MAX_W'(DEF_DIV), MAX_W'(DEF_HIGH));

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] high_q;
    logic             inv_q;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_high;
    logic             sh_inv;

    eff_cfg_t         sh_eff;
    logic             cfg_unused;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] nxt_div;
    logic [CNT_W-1:0] nxt_high;
    logic             nxt_inv;

    assign sh_eff     = sanitise(MAX_W'(sh_div), MAX_W'(sh_high));
    assign cfg_unused = ^sh_eff;
    assign wrap       = (cnt == div_q - 1'b1);
    assign next_cnt   = wrap ? '0 : cnt + 1'b1;

    // pend is sampled before this edge, so a write landing on a wrap waits one more period.
    always_comb begin
        apply = 1'b0;
        case (state)
            ST_STOP: apply = pend;
            default: apply = pend && wrap;
        endcase
    end

    always_comb begin
        nxt_div  = div_q;
        nxt_high = high_q;
        nxt_inv  = inv_q;
        if (apply) begin
            nxt_div  = CNT_W'(sh_eff.div);
            nxt_high = CNT_W'(sh_eff.high);
            nxt_inv  = sh_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_STOP;
            cnt     <= '0;
            div_q   <= CNT_W'(DEF_EFF.div);
            high_q  <= CNT_W'(DEF_EFF.high);
            inv_q   <= 1'b0;
            sh_div  <= CNT_W'(DEF_DIV);
            sh_high <= CNT_W'(DEF_HIGH);
            sh_inv  <= 1'b0;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            div_q  <= nxt_div;
            high_q <= nxt_high;
            inv_q  <= nxt_inv;
            if (wr) begin
                sh_div  <= wr_div;
                sh_high <= wr_high;
                sh_inv  <= wr_inv;
                pend    <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
            case (state)
                ST_STOP: begin
                    cnt <= '0;
                    if (en) begin
                        state   <= ST_RUN;
                        tick    <= 1'b1;
                        clk_out <= (nxt_high != '0) ^ nxt_inv;
                    end else begin
                        tick    <= 1'b0;
                        clk_out <= nxt_inv;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (state == ST_DRAIN && !en && wrap) begin
                        state   <= ST_STOP;
                        cnt     <= '0;
                        tick    <= 1'b0;
                        clk_out <= nxt_inv;
                    end else begin
                        state   <= en ? ST_RUN : ST_DRAIN;
                        cnt     <= next_cnt;
                        tick    <= wrap;
                        clk_out <= (next_cnt < nxt_high) ^ nxt_inv;
                    end
                end
                default: state <= ST_STOP;
            endcase
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free period-boundary reload.
// Optional output inversion (cfg_inv port) when CLK_DIV_GEN_INV_EN is defined.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter  int unsigned NUM_CH   = 4,
    parameter  int unsigned CNT_W    = 31,
    parameter  int unsigned DEF_DIV  = 125000000,
    parameter  int unsigned DEF_HIGH = 62500000,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLK_DIV_GEN_INV_EN
    input  logic              cfg_inv,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic [NUM_CH-1:0] sel;
    logic              inv_in;

`ifdef CLK_DIV_GEN_INV_EN
    assign inv_in = cfg_inv;
`else
    assign inv_in = 1'b0;
`endif

    // Out-of-range channel numbers select nothing, so they read as ready and are dropped.
    assign cfg_ready = ~|(sel & pend);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i] = (cfg_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[i]),
            .wr     (cfg_valid && cfg_ready && sel[i]),
            .wr_div (cfg_div),
            .wr_high(cfg_high),
            .wr_inv (inv_in),
            .clk_out(clk_out[i]),
            .tick   (tick[i]),
            .pend   (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: vector table plus scoreboard-driven corner sequences.
module tb_clk_div_gen;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 31;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic              cfg_inv;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        string name;
        int    ch;
        bit    co;
        bit    tk;
    } exp_t;

    typedef struct {
        string       name;
        int unsigned div;
        int unsigned high;
        bit [0:7]    co;
        bit [0:7]    tk;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    clk_div_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (10),
        .DEF_HIGH(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
`ifdef CLK_DIV_GEN_INV_EN
        .cfg_inv  (cfg_inv),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input int ch, input bit co, input bit tk);
        exp_t e;
        e.name = name;
        e.ch   = ch;
        e.co   = co;
        e.tk   = tk;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got no entry required one");
        end else begin
            e = sbq.pop_front();
            chk({e.name, "_clk_out"}, 32'(clk_out[e.ch]), 32'(e.co));
            chk({e.name, "_tick"}, 32'(tick[e.ch]), 32'(e.tk));
        end
    endtask

    task automatic expect_n(input string name, input int ch, input bit [0:15] co,
                            input bit [0:15] tk, input int n);
        for (int i = 0; i < n; i++) push_exp(name, ch, co[i], tk[i]);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset between clock edges so the checks see an asynchronous clear.
    task automatic reset_dut();
        rst_n     = 1'b0;
        en        = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int ch, input int unsigned div, input int unsigned high);
        cfg_ch    = 2'(ch);
        cfg_div   = CNT_W'(div);
        cfg_high  = CNT_W'(high);
        cfg_valid = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int unsigned div, input int unsigned high);
        drive_cfg(ch, div, high);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"d4h2", 4, 2, 8'b11001100, 8'b10001000};
        vecs[1] = '{"d0h1", 0, 1, 8'b10101010, 8'b10101010};
        vecs[2] = '{"d1h1", 1, 1, 8'b10101010, 8'b10101010};
        vecs[3] = '{"d4h0", 4, 0, 8'b00000000, 8'b10001000};
        vecs[4] = '{"d4h9", 4, 9, 8'b11111111, 8'b10001000};
        vecs[5] = '{"d3h2", 3, 2, 8'b11011011, 8'b10010010};
        vecs[6] = '{"d5h1", 5, 1, 8'b10000100, 8'b10000100};
        vecs[7] = '{"d2h2", 2, 2, 8'b11111111, 8'b10101010};

        en        = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        cfg_inv   = 1'b0;
        #1;

        for (int v = 0; v < 8; v++) begin
            reset_dut();
            cfg_write(0, vecs[v].div, vecs[v].high);
            chk({vecs[v].name, "_pend_set"}, 32'(pend[0]), 32'd1);
            en[0] = 1'b1;
            for (int i = 0; i < 8; i++) push_exp(vecs[v].name, 0, vecs[v].co[i], vecs[v].tk[i]);
            for (int i = 0; i < 8; i++) step();
            chk({vecs[v].name, "_pend_clr"}, 32'(pend[0]), 32'd0);
        end

        // Reset values: default divisor 10, high 3 on an unconfigured channel.
        reset_dut();
        en[0] = 1'b1;
        expect_n("def", 0, 16'b1110000000100000, 16'b1000000000100000, 11);

        // Reload while running: no short pulse, new pattern starts at the wrap.
        reset_dut();
        cfg_write(1, 5, 1);
        en[1] = 1'b1;
        expect_n("a_pre", 1, 16'b1000000000000000, 16'b1000000000000000, 2);
        drive_cfg(1, 3, 2);
        expect_n("a_wr", 1, 16'b0, 16'b0, 1);
        cfg_valid = 1'b0;
        chk("a_pend_wr", 32'(pend[1]), 32'd1);
        expect_n("a_hold", 1, 16'b0, 16'b0, 2);
        chk("a_pend_hold", 32'(pend[1]), 32'd1);
        expect_n("a_new", 1, 16'b1101101100000000, 16'b1001001000000000, 9);
        chk("a_pend_clr", 32'(pend[1]), 32'd0);

        // Drain: en drops at cnt=1, period still lasts 6 cycles, then stop low.
        reset_dut();
        cfg_write(2, 6, 3);
        en[2] = 1'b1;
        expect_n("b_run", 2, 16'b1100000000000000, 16'b1000000000000000, 2);
        en[2] = 1'b0;
        expect_n("b_drain", 2, 16'b1000000000000000, 16'b0, 6);
        en[2] = 1'b1;
        expect_n("b_re1", 2, 16'b1100000000000000, 16'b1000000000000000, 2);
        en[2] = 1'b0;
        expect_n("b_re2", 2, 16'b1000000000000000, 16'b0, 1);
        en[2] = 1'b1;
        expect_n("b_re3", 2, 16'b0001110000000000, 16'b0001000000000000, 6);

        // Write on the wrap edge waits a period; a second write stalls while pending.
        reset_dut();
        cfg_write(3, 4, 2);
        en[3] = 1'b1;
        expect_n("c_run", 3, 16'b1100000000000000, 16'b1000000000000000, 4);
        drive_cfg(3, 2, 1);
        expect_n("c_wrap", 3, 16'b1000000000000000, 16'b1000000000000000, 1);
        cfg_valid = 1'b0;
        chk("c_pend_wrap", 32'(pend[3]), 32'd1);
        drive_cfg(3, 6, 6);
        #1;
        chk("c_ready_stall", 32'(cfg_ready), 32'd0);
        expect_n("c_stall", 3, 16'b1000000000000000, 16'b0, 3);
        cfg_valid = 1'b0;
        chk("c_pend_stall", 32'(pend[3]), 32'd1);
        expect_n("c_new", 3, 16'b1010000000000000, 16'b1010000000000000, 4);
        chk("c_pend_clr", 32'(pend[3]), 32'd0);
        chk("c_ready_clr", 32'(cfg_ready), 32'd1);

        reset_dut();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
